// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-master memory arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_t;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    localparam logic [31:0] MMIO_ADDR_A = 32'hf6fff070;
    localparam logic [31:0] MMIO_ADDR_B = 32'hffffff00;

endpackage

// File: rtl/mem_align_chk.sv
// Combinational misalignment detector for one master's access.
module mem_align_chk
    import mem_arbiter_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic [1:0] addr_lo,
    output logic       misaligned
);

    // Halfwords only fault when they would straddle a word boundary.
    always_comb begin
        misaligned = 1'b1;
        case (funct3)
            LB, LBU: misaligned = 1'b0;
            LH, LHU: misaligned = (addr_lo == 2'b11);
            LW:      misaligned = (addr_lo != 2'b00);
            default: misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master memory arbiter: round-robin with bounded read-modify-write locking.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int LOCK_MAX = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic        m0_lock,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [2:0]  m0_funct3,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic        m1_lock,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [2:0]  m1_funct3,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic        mem_write,
    output logic [31:0] w_addr,
    output logic [31:0] r_addr,
    output logic [31:0] w_data,
    output logic [2:0]  funct3,
    input  logic [31:0] r_data
);

    localparam logic [4:0] LOCK_LIM = 5'(LOCK_MAX);

    arb_state_t state, state_nx;
    logic       ptr, ptr_nx;
    logic [4:0] lock_cnt, lock_cnt_nx, cnt_inc;
    logic       gnt0, gnt1, mis0, mis1, win_lock, other_req;

    mem_align_chk u_chk0 (.funct3(m0_funct3), .addr_lo(m0_addr[1:0]), .misaligned(mis0));
    mem_align_chk u_chk1 (.funct3(m1_funct3), .addr_lo(m1_addr[1:0]), .misaligned(mis1));

    // ptr=1 favours m1 on an IDLE tie; grants are gated by reset directly.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_n) begin
            case (state)
                LOCK0: gnt0 = m0_req;
                LOCK1: gnt1 = m1_req;
                default: begin
                    if (m0_req && m1_req) begin
                        gnt0 = ~ptr;
                        gnt1 = ptr;
                    end else begin
                        gnt0 = m0_req;
                        gnt1 = m1_req;
                    end
                end
            endcase
        end
    end

    always_comb begin
        state_nx    = state;
        ptr_nx      = ptr;
        lock_cnt_nx = lock_cnt;
        win_lock    = gnt0 ? m0_lock : m1_lock;
        other_req   = gnt0 ? m1_req : m0_req;
        cnt_inc     = (lock_cnt >= LOCK_LIM) ? LOCK_LIM : lock_cnt + 5'd1;
        if (gnt0 || gnt1) begin
            ptr_nx = gnt0;
            if (win_lock && !(other_req && cnt_inc >= LOCK_LIM)) begin
                state_nx    = gnt0 ? LOCK0 : LOCK1;
                lock_cnt_nx = cnt_inc;
            end else begin
                state_nx    = IDLE;
                lock_cnt_nx = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= 1'b0;
            lock_cnt <= '0;
        end else begin
            state    <= state_nx;
            ptr      <= ptr_nx;
            lock_cnt <= lock_cnt_nx;
        end
    end

    always_comb begin
        mem_write = 1'b0;
        w_addr    = '0;
        r_addr    = '0;
        w_data    = '0;
        funct3    = '0;
        if (gnt0) begin
            mem_write = m0_we & ~mis0;
            w_addr    = m0_addr;
            r_addr    = m0_addr;
            w_data    = m0_wdata;
            funct3    = m0_funct3;
        end else if (gnt1) begin
            mem_write = m1_we & ~mis1;
            w_addr    = m1_addr;
            r_addr    = m1_addr;
            w_data    = m1_wdata;
            funct3    = m1_funct3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m0_rvalid <= 1'b0;
            m0_err    <= 1'b0;
            m0_rdata  <= '0;
            m1_rvalid <= 1'b0;
            m1_err    <= 1'b0;
            m1_rdata  <= '0;
        end else begin
            m0_rvalid <= gnt0;
            m0_err    <= gnt0 & mis0;
            m1_rvalid <= gnt1;
            m1_err    <= gnt1 & mis1;
            if (gnt0) m0_rdata <= (!m0_we && !mis0) ? r_data : '0;
            if (gnt1) m1_rdata <= (!m1_we && !mis1) ? r_data : '0;
        end
    end

    assign m0_gnt = gnt0;
    assign m1_gnt = gnt1;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized run against a transaction-level model.
module tb_mem_arbiter;

    localparam int LOCK_MAX = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [2:0]  m0_funct3, m1_funct3;
    logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_write;
    logic [31:0] w_addr, r_addr, w_data, r_data;
    logic [2:0]  funct3;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: favoured master on a tie, current lock owner (-1 none), locked grant count.
    int fav, own, cnt;

    mem_arbiter #(.LOCK_MAX(LOCK_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_funct3(m0_funct3), .m0_gnt(m0_gnt),
        .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_funct3(m1_funct3), .m1_gnt(m1_gnt),
        .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .mem_write(mem_write), .w_addr(w_addr), .r_addr(r_addr),
        .w_data(w_data), .funct3(funct3), .r_data(r_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_fn(logic [31:0] a);
        return (a == 32'h100) ? 32'hDEADBEEF : ((a ^ 32'h5A5AA5A5) + 32'h1357);
    endfunction

    assign r_data = mem_fn(r_addr);

    function automatic bit mdl_mis(logic [2:0] f, logic [31:0] a);
        case (f)
            3'b000, 3'b100: return 1'b0;
            3'b001, 3'b101: return a[1:0] == 2'b11;
            3'b010:         return a[1:0] != 2'b00;
            default:        return 1'b1;
        endcase
    endfunction

    function automatic int mdl_winner(bit r0, bit r1);
        if (own == 0) return r0 ? 0 : -1;
        if (own == 1) return r1 ? 1 : -1;
        if (r0 && r1) return fav;
        if (r0) return 0;
        if (r1) return 1;
        return -1;
    endfunction

    task automatic mdl_commit(int w, bit lk, bit oreq);
        if (w < 0) return;
        fav = 1 - w;
        if (lk) begin
            cnt = (own == w) ? ((cnt >= LOCK_MAX) ? LOCK_MAX : cnt + 1) : 1;
            own = w;
            if (oreq && cnt >= LOCK_MAX) begin
                own = -1;
                cnt = 0;
            end
        end else begin
            own = -1;
            cnt = 0;
        end
    endtask

    task automatic set_m0(logic req, logic we, logic lk, logic [31:0] a, logic [31:0] d, logic [2:0] f);
        m0_req = req; m0_we = we; m0_lock = lk; m0_addr = a; m0_wdata = d; m0_funct3 = f;
    endtask

    task automatic set_m1(logic req, logic we, logic lk, logic [31:0] a, logic [31:0] d, logic [2:0] f);
        m1_req = req; m1_we = we; m1_lock = lk; m1_addr = a; m1_wdata = d; m1_funct3 = f;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        set_m0(0, 0, 0, 0, 0, 0);
        set_m1(0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        fav = 0; own = -1; cnt = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #2;
        set_m0(1, 1, 0, 32'h100, 32'h1234, 3'b010);
        #1;
        n_tests++; if (m0_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_gnt: got %b want 0", m0_gnt); end
        n_tests++; if (mem_write !== 1'b0) begin n_fail++; $display("FAIL reset_mem_write: got %b want 0", mem_write); end
        n_tests++; if (w_addr !== 32'h0) begin n_fail++; $display("FAIL reset_w_addr: got %h want 0", w_addr); end
        @(posedge clk); #1;
        n_tests++; if ({m0_rvalid, m1_rvalid, m0_err, m1_err} !== 4'b0) begin n_fail++; $display("FAIL reset_rvalid_err: got %b want 0000", {m0_rvalid, m1_rvalid, m0_err, m1_err}); end
        n_tests++; if ({m0_rdata, m1_rdata} !== 64'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", {m0_rdata, m1_rdata}); end
        set_m0(0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        fav = 0; own = -1; cnt = 0;
    endtask

    task automatic test_load();
        do_reset();
        set_m0(1, 0, 0, 32'h100, 32'h0, 3'b010);
        #4;
        n_tests++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin n_fail++; $display("FAIL load_gnt: got %b%b want 10", m0_gnt, m1_gnt); end
        n_tests++; if (r_addr !== 32'h100 || mem_write !== 1'b0) begin n_fail++; $display("FAIL load_bus: got addr %h we %b want 100/0", r_addr, mem_write); end
        @(posedge clk); #1;
        set_m0(0, 0, 0, 0, 0, 0);
        n_tests++; if (m0_rvalid !== 1'b1) begin n_fail++; $display("FAIL load_rvalid: got %b want 1", m0_rvalid); end
        n_tests++; if (m0_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL load_rdata: got %h want deadbeef", m0_rdata); end
        n_tests++; if (m0_err !== 1'b0) begin n_fail++; $display("FAIL load_err: got %b want 0", m0_err); end
        @(posedge clk); #1;
        n_tests++; if (m0_rvalid !== 1'b0) begin n_fail++; $display("FAIL load_rvalid_pulse: got %b want 0", m0_rvalid); end
    endtask

    task automatic test_alternate();
        int exp;
        do_reset();
        set_m0(1, 0, 0, 32'h10, 32'h0, 3'b010);
        set_m1(1, 0, 0, 32'h20, 32'h0, 3'b010);
        for (int c = 0; c < 8; c++) begin
            exp = c % 2;
            #4;
            n_tests++; if (m0_gnt !== (exp == 0) || m1_gnt !== (exp == 1)) begin n_fail++; $display("FAIL alt_gnt c%0d: got %b%b want m%0d", c, m0_gnt, m1_gnt, exp); end
            n_tests++; if (r_addr !== ((exp == 1) ? 32'h20 : 32'h10)) begin n_fail++; $display("FAIL alt_addr c%0d: got %h", c, r_addr); end
            @(posedge clk); #1;
            n_tests++; if (m0_rvalid !== (exp == 0) || m1_rvalid !== (exp == 1)) begin n_fail++; $display("FAIL alt_rvalid c%0d: got %b%b want m%0d", c, m0_rvalid, m1_rvalid, exp); end
        end
        set_m0(0, 0, 0, 0, 0, 0);
        set_m1(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_lock_limit();
        int exp;
        int m1_grants = 0;
        do_reset();
        set_m1(1, 0, 1, 32'h300, 32'h0, 3'b010);
        for (int c = 0; c <= 16; c++) begin
            if (c == 1) set_m0(1, 0, 0, 32'h400, 32'h0, 3'b010);
            exp = (c < 16) ? 1 : 0;
            #4;
            if (m1_gnt === 1'b1) m1_grants++;
            n_tests++; if (m0_gnt !== (exp == 0) || m1_gnt !== (exp == 1)) begin n_fail++; $display("FAIL lock_gnt c%0d: got %b%b want m%0d", c, m0_gnt, m1_gnt, exp); end
            @(posedge clk); #1;
        end
        n_tests++; if (m1_grants != 16) begin n_fail++; $display("FAIL lock_count: got %0d want 16", m1_grants); end
        set_m0(0, 0, 0, 0, 0, 0);
        set_m1(0, 0, 0, 0, 0, 0);
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic        mis;
    } acase_t;

    task automatic test_align_table();
        acase_t tbl[10];
        logic [31:0] exp_rd;
        tbl[0] = '{1'b1, 3'b010, 32'h102, 1'b1};
        tbl[1] = '{1'b0, 3'b001, 32'h203, 1'b1};
        tbl[2] = '{1'b0, 3'b001, 32'h201, 1'b0};
        tbl[3] = '{1'b0, 3'b101, 32'h003, 1'b1};
        tbl[4] = '{1'b0, 3'b010, 32'h104, 1'b0};
        tbl[5] = '{1'b0, 3'b000, 32'h003, 1'b0};
        tbl[6] = '{1'b0, 3'b011, 32'h000, 1'b1};
        tbl[7] = '{1'b1, 3'b110, 32'h000, 1'b1};
        tbl[8] = '{1'b0, 3'b111, 32'h008, 1'b1};
        tbl[9] = '{1'b1, 3'b001, 32'h002, 1'b0};
        do_reset();
        for (int i = 0; i < 10; i++) begin
            set_m0(1, tbl[i].we, 0, tbl[i].addr, 32'hCAFE0000 + i, tbl[i].f3);
            #4;
            n_tests++; if (m0_gnt !== 1'b1) begin n_fail++; $display("FAIL align_gnt #%0d: got %b want 1", i, m0_gnt); end
            n_tests++; if (mem_write !== (tbl[i].we & ~tbl[i].mis)) begin n_fail++; $display("FAIL align_mem_write #%0d: got %b want %b", i, mem_write, tbl[i].we & ~tbl[i].mis); end
            @(posedge clk); #1;
            exp_rd = (!tbl[i].we && !tbl[i].mis) ? mem_fn(tbl[i].addr) : 32'h0;
            n_tests++; if (m0_rvalid !== 1'b1 || m0_err !== tbl[i].mis) begin n_fail++; $display("FAIL align_resp #%0d: got rvalid %b err %b want 1/%b", i, m0_rvalid, m0_err, tbl[i].mis); end
            n_tests++; if (m0_rdata !== exp_rd) begin n_fail++; $display("FAIL align_rdata #%0d: got %h want %h", i, m0_rdata, exp_rd); end
        end
        set_m0(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_store_byte();
        do_reset();
        set_m1(1, 1, 0, 32'h203, 32'h5A, 3'b000);
        #4;
        n_tests++; if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0) begin n_fail++; $display("FAIL sb_gnt: got %b%b want 01", m0_gnt, m1_gnt); end
        n_tests++; if (mem_write !== 1'b1 || w_addr !== 32'h203 || funct3 !== 3'b000) begin n_fail++; $display("FAIL sb_bus: got we %b addr %h f3 %b want 1/203/000", mem_write, w_addr, funct3); end
        n_tests++; if (w_data !== 32'h5A) begin n_fail++; $display("FAIL sb_wdata: got %h want 5a", w_data); end
        @(posedge clk); #1;
        set_m1(0, 0, 0, 0, 0, 0);
        n_tests++; if (m1_rvalid !== 1'b1 || m1_err !== 1'b0 || m1_rdata !== 32'h0) begin n_fail++; $display("FAIL sb_resp: got rvalid %b err %b rdata %h want 1/0/0", m1_rvalid, m1_err, m1_rdata); end
    endtask

    task automatic test_reset_mid_lock();
        do_reset();
        set_m0(1, 0, 1, 32'h100, 32'h0, 3'b010);
        #4;
        n_tests++; if (m0_gnt !== 1'b1) begin n_fail++; $display("FAIL midrst_gnt: got %b want 1", m0_gnt); end
        @(posedge clk); #1;
        n_tests++; if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL midrst_pre: got %b %h want 1/deadbeef", m0_rvalid, m0_rdata); end
        rst_n = 1'b0;
        #1;
        n_tests++; if (m0_gnt !== 1'b0 || mem_write !== 1'b0 || r_addr !== 32'h0) begin n_fail++; $display("FAIL midrst_comb: got gnt %b we %b addr %h want 0", m0_gnt, mem_write, r_addr); end
        n_tests++; if (m0_rvalid !== 1'b0 || m0_rdata !== 32'h0 || m0_err !== 1'b0) begin n_fail++; $display("FAIL midrst_regs: got %b %h %b want 0", m0_rvalid, m0_rdata, m0_err); end
        @(posedge clk); #1;
        set_m0(0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_tests++; if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin n_fail++; $display("FAIL midrst_no_rvalid: got %b%b want 00", m0_rvalid, m1_rvalid); end
        set_m0(1, 0, 0, 32'h40, 32'h0, 3'b010);
        set_m1(1, 0, 0, 32'h80, 32'h0, 3'b010);
        #4;
        n_tests++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin n_fail++; $display("FAIL midrst_first: got %b%b want 10", m0_gnt, m1_gnt); end
        @(posedge clk); #1;
        set_m0(0, 0, 0, 0, 0, 0);
        set_m1(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_random();
        bit          p0 = 0, p1 = 0;
        logic        we0, we1, lk0, lk1;
        logic [31:0] a0, a1, d0, d1;
        logic [2:0]  f0, f1;
        int          w;
        logic        ewe;
        logic [31:0] ea, ed, erd;
        logic [2:0]  ef;
        bit          emis;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if (!p0 && $urandom_range(0, 3) != 0) begin
                p0 = 1; we0 = 1'($urandom_range(0, 1)); lk0 = ($urandom_range(0, 3) == 0);
                a0 = $urandom & 32'h0000_0FFF; d0 = $urandom; f0 = 3'($urandom_range(0, 7));
            end
            if (!p1 && $urandom_range(0, 3) != 0) begin
                p1 = 1; we1 = 1'($urandom_range(0, 1)); lk1 = ($urandom_range(0, 3) == 0);
                a1 = $urandom & 32'h0000_0FFF; d1 = $urandom; f1 = 3'($urandom_range(0, 7));
            end
            set_m0(p0, we0, lk0, a0, d0, f0);
            set_m1(p1, we1, lk1, a1, d1, f1);
            w = mdl_winner(p0, p1);
            ewe = 0; ea = 0; ed = 0; ef = 0; emis = 0;
            if (w == 0) begin ea = a0; ed = d0; ef = f0; emis = mdl_mis(f0, a0); ewe = we0 & ~emis; end
            if (w == 1) begin ea = a1; ed = d1; ef = f1; emis = mdl_mis(f1, a1); ewe = we1 & ~emis; end
            erd = (w == 0 && !we0 && !emis) ? mem_fn(a0) : (w == 1 && !we1 && !emis) ? mem_fn(a1) : 32'h0;
            #4;
            n_tests++; if (m0_gnt !== (w == 0) || m1_gnt !== (w == 1)) begin n_fail++; $display("FAIL rnd_gnt c%0d: got %b%b want winner %0d", c, m0_gnt, m1_gnt, w); end
            n_tests++; if (mem_write !== ewe || w_addr !== ea || r_addr !== ea || w_data !== ed || funct3 !== ef) begin
                n_fail++; $display("FAIL rnd_bus c%0d: got %b %h %h %h %b want %b %h %h %b", c, mem_write, w_addr, r_addr, w_data, funct3, ewe, ea, ed, ef);
            end
            @(posedge clk); #1;
            n_tests++; if (m0_rvalid !== (w == 0) || m1_rvalid !== (w == 1)) begin n_fail++; $display("FAIL rnd_rvalid c%0d: got %b%b want winner %0d", c, m0_rvalid, m1_rvalid, w); end
            if (w == 0) begin
                n_tests++; if (m0_err !== emis || m0_rdata !== erd) begin n_fail++; $display("FAIL rnd_resp0 c%0d: got %b %h want %b %h", c, m0_err, m0_rdata, emis, erd); end
                mdl_commit(0, lk0, p1);
                p0 = 0;
            end else if (w == 1) begin
                n_tests++; if (m1_err !== emis || m1_rdata !== erd) begin n_fail++; $display("FAIL rnd_resp1 c%0d: got %b %h want %b %h", c, m1_err, m1_rdata, emis, erd); end
                mdl_commit(1, lk1, p0);
                p1 = 0;
            end
        end
        set_m0(0, 0, 0, 0, 0, 0);
        set_m1(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        set_m0(0, 0, 0, 0, 0, 0);
        set_m1(0, 0, 0, 0, 0, 0);
        fav = 0; own = -1; cnt = 0;
        test_reset();
        test_load();
        test_alternate();
        test_lock_limit();
        test_align_table();
        test_store_byte();
        test_reset_mid_lock();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
